// File: rtl/conv_stream_tx.sv
// ---------------------------------------------------------------------------
// conv_stream_tx
//
// Transmit side of the conv-to-pooling interface. The convolution engine
// fills a LEN x LEN feature-map buffer through a simple write port. On start,
// the whole map is streamed in raster order, one word per cycle, on conv_out
// qualified by en_reg. The block then raises en_pooling and holds it until
// the pooling stage answers with done_pooling. A one-cycle done pulse closes
// the transaction.
//
// Optional feature (macro POOL_WDOG_EN):
//   A watchdog counts cycles spent waiting in POOL. If done_pooling has not
//   arrived within WDOG_CYCLES cycles, the transaction is abandoned:
//   en_pooling drops, wdog_err pulses for one cycle, done stays low and the
//   block returns straight to IDLE. The wdog_err port exists only when the
//   macro is defined.
//
// Parameters:
//   LEN          feature-map side length (buffer holds LEN*LEN words)
//   DW           data width of wr_data / conv_out
//   AW           buffer address width, 2**AW >= LEN*LEN
//   WDOG_CYCLES  POOL timeout in cycles (POOL_WDOG_EN builds only)
//
// Ports:
//   clk           clock, all logic on the rising edge
//   reset         synchronous active-high reset
//   wr_en         buffer write strobe (honoured only in IDLE)
//   wr_addr       raster write address row*LEN+col
//   wr_data       buffer write data
//   start         request to stream the buffered map (IDLE only)
//   done_pooling  completion flag returned by the pooling stage
//   en_reg        conv_out valid, one sample per cycle during the stream
//   conv_out      streamed sample (registered)
//   en_pooling    pooling enable, high while waiting for done_pooling
//   busy          high from start acceptance until return to IDLE
//   wdog_err      one-cycle POOL timeout pulse (POOL_WDOG_EN only)
//   done          one-cycle completion pulse
// ---------------------------------------------------------------------------
module conv_stream_tx #(
  parameter int LEN         = 8,
  parameter int DW          = 16,
  parameter int AW          = 6,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic          done_pooling,
  output logic          en_reg,
  output logic [DW-1:0] conv_out,
  output logic          en_pooling,
  output logic          busy,
`ifdef POOL_WDOG_EN
  output logic          wdog_err,
`endif
  output logic          done
);

  localparam int DEPTH = LEN * LEN;

  // The index runs one bit wider than the address so that it can reach
  // DEPTH itself, which is the "stream finished" marker.
  localparam logic [AW:0] DEPTH_IDX = (AW + 1)'(DEPTH);
  localparam logic [AW:0] IDX_ONE   = (AW + 1)'(1);
  localparam logic [AW:0] IDX_ZERO  = '0;

  // Elaboration-time sanity checks on the configuration.
  if ((2 ** AW) < DEPTH) begin : g_bad_aw
    $error("conv_stream_tx: AW too small for LEN*LEN words");
  end
  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("conv_stream_tx: WDOG_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_POOL,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   idx_q, idx_d;
  logic          en_reg_q, en_reg_d;
  logic [DW-1:0] conv_out_q, conv_out_d;
  logic          en_pool_q, en_pool_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

`ifdef POOL_WDOG_EN
  localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);
  localparam logic [WW-1:0] WDOG_ONE  = WW'(1);

  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          wdog_err_q, wdog_err_d;
`endif

  // Feature-map buffer. It is not reset: contents survive reset and are
  // only changed by writes accepted while IDLE, which keeps the map stable
  // for the whole duration of a stream.
  logic [DW-1:0] mem_q [DEPTH];
  logic          wr_ok;
  logic [DW-1:0] rd_data;

  assign wr_ok   = !reset && (state_q == S_IDLE) && wr_en &&
                   ({1'b0, wr_addr} < DEPTH_IDX);
  assign rd_data = mem_q[idx_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Next-state and output logic. en_reg and done are pulses and default
  // low every cycle; the remaining outputs hold unless a transition changes
  // them. conv_out keeps the last sample once the stream ends.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    en_reg_d   = 1'b0;
    conv_out_d = conv_out_q;
    en_pool_d  = en_pool_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef POOL_WDOG_EN
    wcnt_d     = wcnt_q;
    wdog_err_d = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_STREAM;
          busy_d  = 1'b1;
          idx_d   = IDX_ZERO;
        end
      end

      S_STREAM: begin
        // One sample per edge while idx is below DEPTH; the edge that finds
        // idx == DEPTH drops en_reg and raises en_pooling together, so the
        // two are never high at the same time.
        if (idx_q == DEPTH_IDX) begin
          state_d   = S_POOL;
          en_pool_d = 1'b1;
`ifdef POOL_WDOG_EN
          wcnt_d    = '0;
`endif
        end else begin
          en_reg_d   = 1'b1;
          conv_out_d = rd_data;
          idx_d      = idx_q + IDX_ONE;
        end
      end

      S_POOL: begin
        if (done_pooling) begin
          state_d   = S_DONE;
          en_pool_d = 1'b0;
          done_d    = 1'b1;
        end
`ifdef POOL_WDOG_EN
        else if (wcnt_q == WDOG_LAST) begin
          // Pooling never answered: abandon without a done pulse.
          state_d    = S_IDLE;
          en_pool_d  = 1'b0;
          busy_d     = 1'b0;
          wdog_err_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WDOG_ONE;
        end
`endif
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers. Reset aborts any stream or pooling wait on
  // the spot; done is cleared, so an aborted run never reports completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      en_reg_q   <= 1'b0;
      conv_out_q <= '0;
      en_pool_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef POOL_WDOG_EN
      wcnt_q     <= '0;
      wdog_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      en_reg_q   <= en_reg_d;
      conv_out_q <= conv_out_d;
      en_pool_q  <= en_pool_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef POOL_WDOG_EN
      wcnt_q     <= wcnt_d;
      wdog_err_q <= wdog_err_d;
`endif
    end
  end

  assign en_reg     = en_reg_q;
  assign conv_out   = conv_out_q;
  assign en_pooling = en_pool_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef POOL_WDOG_EN
  assign wdog_err   = wdog_err_q;
`endif

endmodule

// File: tb/tb_conv_stream_tx.sv
// ---------------------------------------------------------------------------
// tb_conv_stream_tx
//
// Self-checking bench for conv_stream_tx (LEN=8, DW=16, AW=6). A timeline
// model records the edge at which each transaction starts and ends and
// derives every expected control output from those edge numbers. Streamed
// samples are pushed into a scoreboard queue when a start is accepted and
// popped by an independent monitor whenever en_reg is high.
// Build with +define+POOL_WDOG_EN to also exercise the watchdog
// (WDOG_CYCLES=16).
// ---------------------------------------------------------------------------
module tb_conv_stream_tx;

  localparam int N    = 64;
  localparam int WDOG = 16;
  localparam int BIG  = 1 << 30;

  logic        clk;
  logic        resetR;
  logic        wrEn;
  logic [5:0]  wrAddr;
  logic [15:0] wrData;
  logic        startR;
  logic        donePool;
  logic        enReg;
  logic [15:0] convOut;
  logic        enPooling;
  logic        busyO;
  logic        doneO;
`ifdef POOL_WDOG_EN
  logic        wdogErr;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  // Timeline model: edge numbers of the current transaction.
  int          edgeNo    = 0;
  bit          runActive = 0;
  bit          resetEdge = 0;
  int          kEdge     = 0;
  int          doneEdge  = -1;
  int          wEdge     = -1;
  int          poolEnd   = BIG;
  int          idleFrom  = BIG;
  logic [15:0] refMem [N];
  logic [15:0] lastSample = '0;
  logic [15:0] expQ [$];

  conv_stream_tx #(
    .LEN(8),
    .DW(16),
    .AW(6),
    .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk),
    .reset(resetR),
    .wr_en(wrEn),
    .wr_addr(wrAddr),
    .wr_data(wrData),
    .start(startR),
    .done_pooling(donePool),
    .en_reg(enReg),
    .conv_out(convOut),
    .en_pooling(enPooling),
    .busy(busyO),
`ifdef POOL_WDOG_EN
    .wdog_err(wdogErr),
`endif
    .done(doneO)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compareVal(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)",
               name, act, exp, edgeNo);
    end
  endtask

  // Advance the model by one rising edge using the inputs now applied.
  function automatic void modelEdge();
    bit idleNow;
    edgeNo++;
    resetEdge = resetR;
    if (resetR) begin
      runActive  = 0;
      lastSample = '0;
      expQ.delete();
      return;
    end
    idleNow = !runActive || (edgeNo >= idleFrom);
    if (idleNow) begin
      if (wrEn && (int'(wrAddr) < N)) refMem[wrAddr] = wrData;
      if (startR) begin
        runActive = 1;
        kEdge     = edgeNo;
        doneEdge  = -1;
        wEdge     = -1;
        poolEnd   = BIG;
        idleFrom  = BIG;
        for (int i = 0; i < N; i++) expQ.push_back(refMem[i]);
        lastSample = refMem[N-1];
      end
    end else if ((poolEnd == BIG) && (edgeNo >= kEdge + N + 2)) begin
      if (donePool) begin
        doneEdge = edgeNo;
        poolEnd  = edgeNo;
        idleFrom = edgeNo + 2;
      end
`ifdef POOL_WDOG_EN
      else if (edgeNo == kEdge + N + 1 + WDOG) begin
        wEdge    = edgeNo;
        poolEnd  = edgeNo;
        idleFrom = edgeNo + 1;
      end
`endif
    end
  endfunction

  // Compare control outputs against the timeline after each edge.
  task automatic checkOutput();
    bit eReg, ePool, eDone, eBusy, eWdog, inPool;
    int n;
    n      = edgeNo;
    eReg   = 0;
    ePool  = 0;
    eDone  = 0;
    eBusy  = 0;
    eWdog  = 0;
    if (runActive && !resetEdge) begin
      eReg  = (n >= kEdge + 1) && (n <= kEdge + N);
      ePool = (n >= kEdge + N + 1) && (n < poolEnd);
      eDone = (n == doneEdge);
      eBusy = (n >= kEdge) && (n < idleFrom - 1);
      eWdog = (n == wEdge);
    end
    inPool = ePool && !eReg;
    compareVal("en_reg", enReg, eReg);
    compareVal("en_pooling", enPooling, ePool);
    compareVal("done", doneO, eDone);
    compareVal("busy", busyO, eBusy);
`ifdef POOL_WDOG_EN
    compareVal("wdog_err", wdogErr, eWdog);
`else
    if (eWdog) compareVal("wdog_model", 32'd1, 32'd0);
`endif
    if (resetEdge) compareVal("conv_out_reset", convOut, 32'd0);
    if (inPool) compareVal("conv_out_hold", convOut, lastSample);
  endtask

  // Apply one cycle of inputs, then check the result on the falling edge.
  task automatic applyStimulus(input bit rst, input bit we, input int addr,
                               input int data, input bit st, input bit dp);
    logic [31:0] a32, d32;
    a32      = addr;
    d32      = data;
    resetR   = rst;
    wrEn     = we;
    wrAddr   = a32[5:0];
    wrData   = d32[15:0];
    startR   = st;
    donePool = dp;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idleCycles(input int cnt, input bit dp);
    for (int i = 0; i < cnt; i++) applyStimulus(0, 0, 0, 0, 0, dp);
  endtask

  task automatic runOnce(input int poolDelay);
    applyStimulus(0, 0, 0, 0, 1, 0);
    idleCycles(N + 1 + poolDelay - 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    idleCycles(3, 0);
  endtask

  // Scoreboard monitor: every valid sample must match the oldest expected
  // word; a sample with nothing expected is itself an error.
  always @(negedge clk) begin
    if (enReg === 1'b1) begin
      if (expQ.size() == 0) begin
        compareVal("unexpected_sample", convOut, 32'hDEAD_0000);
      end else begin
        compareVal("conv_out", convOut, expQ.pop_front());
      end
    end
  end

  // Directed scenarios followed by a randomized phase.
  initial begin
    resetR   = 1'b1;
    wrEn     = 1'b0;
    wrAddr   = '0;
    wrData   = '0;
    startR   = 1'b0;
    donePool = 1'b0;
    for (int i = 0; i < N; i++) refMem[i] = 'x;

    $display("[TB] reset and buffer load");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) applyStimulus(0, 1, i, i, 0, 0);

    $display("[TB] stream 0..63, done_pooling 10 cycles into POOL");
    runOnce(10);

    $display("[TB] start and write ignored mid-stream");
    applyStimulus(0, 0, 0, 0, 1, 0);
    idleCycles(20, 0);
    applyStimulus(0, 1, 5, 16'hFFFF, 1, 0);
    idleCycles(N + 1 - 21 + 4, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    idleCycles(3, 0);
    runOnce(int'($urandom_range(1, 20)));

    $display("[TB] reset mid-stream then restart");
    applyStimulus(0, 0, 0, 0, 1, 0);
    idleCycles(30, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    runOnce(5);

    $display("[TB] done_pooling held high through a run");
    applyStimulus(0, 0, 0, 0, 1, 1);
    idleCycles(N + 6, 1);
    idleCycles(3, 0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 1500; c++) begin
      applyStimulus($urandom_range(0, 299) == 0, 1'($urandom),
                    int'($urandom_range(0, N - 1)),
                    int'($urandom_range(0, 65535)),
                    $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
    end
    idleCycles(N + 4, 1);
    idleCycles(3, 0);

`ifdef POOL_WDOG_EN
    $display("[TB] watchdog timeout");
    applyStimulus(0, 0, 0, 0, 1, 0);
    idleCycles(N + 1 + WDOG + 10, 0);
    runOnce(3);
`endif

    compareVal("scoreboard_drained", expQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCompared, nMismatched);
    $finish;
  end

endmodule
